// File: rtl/imm_build_sequencer.sv
// Expands a 32-bit constant load into Execute byte-insert micro-ops, LSB lane first.
// Optional SKIP_ZERO_BYTES_EN: omit zero-byte lanes after the src_zero op.
module imm_build_sequencer #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned IMMW  = 11,
    parameter int unsigned REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DATAW-1:0] req_const,
    input  logic [REGW-1:0]  req_rd,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic             uop_use_imm,
    output logic [1:0]       uop_shift_dist,
    output logic [IMMW-1:0]  uop_imm,
    output logic [REGW-1:0]  uop_rd,
    output logic             uop_src_zero,
    output logic             busy,
    output logic             done
);
    localparam int unsigned BYTEW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [DATAW-1:0] cval, cval_d;
    logic [1:0]       shift_d;
    logic [REGW-1:0]  rd_d;
    logic [IMMW-1:0]  imm_d;
    logic             src_zero_d;
    logic             ready_d;
    logic             valid_d;
    logic             done_d;

    logic [1:0]       first_lane;
    logic [1:0]       step_lane;
    logic             last_lane;

    // Lane selection: uop_shift_dist doubles as the lane counter while issuing.
    always_comb begin
        first_lane = 2'd0;
        step_lane  = uop_shift_dist + 2'd1;
        last_lane  = (uop_shift_dist == 2'd3);
`ifdef SKIP_ZERO_BYTES_EN
        for (int i = 3; i >= 0; i--) begin
            if (req_const[i*BYTEW +: BYTEW] != 8'd0) begin
                first_lane = 2'(i);
            end
        end
        last_lane = 1'b1;
        step_lane = uop_shift_dist;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(uop_shift_dist) && cval[i*BYTEW +: BYTEW] != 8'd0) begin
                last_lane = 1'b0;
                step_lane = 2'(i);
            end
        end
`endif
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state;
        cval_d     = cval;
        shift_d    = uop_shift_dist;
        rd_d       = uop_rd;
        src_zero_d = uop_src_zero;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready && !flush) begin
                    state_d    = ISSUE;
                    cval_d     = req_const;
                    rd_d       = req_rd;
                    shift_d    = first_lane;
                    src_zero_d = 1'b1;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (uop_ready) begin
                    src_zero_d = 1'b0;
                    if (last_lane) begin
                        state_d = DONE;
                    end else begin
                        shift_d = step_lane;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Payload is only meaningful while a micro-op is presented.
        if (state_d != ISSUE) begin
            shift_d    = 2'd0;
            rd_d       = '0;
            src_zero_d = 1'b0;
        end

        imm_d   = (state_d == ISSUE) ? IMMW'(cval_d[{shift_d, 3'b000} +: BYTEW]) : '0;
        ready_d = (state_d == IDLE);
        valid_d = (state_d == ISSUE);
        done_d  = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cval           <= '0;
            req_ready      <= 1'b1;
            uop_valid      <= 1'b0;
            uop_use_imm    <= 1'b0;
            uop_shift_dist <= 2'd0;
            uop_imm        <= '0;
            uop_rd         <= '0;
            uop_src_zero   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_d;
            cval           <= cval_d;
            req_ready      <= ready_d;
            uop_valid      <= valid_d;
            uop_use_imm    <= valid_d;
            uop_shift_dist <= shift_d;
            uop_imm        <= imm_d;
            uop_rd         <= rd_d;
            uop_src_zero   <= src_zero_d;
            busy           <= valid_d;
            done           <= done_d;
        end
    end

endmodule

// File: tb/tb_imm_build_sequencer.sv
// Bench for imm_build_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed op lists and latencies.
module tb_imm_build_sequencer;
    localparam int unsigned DATAW = 32;
    localparam int unsigned IMMW  = 11;
    localparam int unsigned REGW  = 5;
`ifdef SKIP_ZERO_BYTES_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [DATAW-1:0] req_const;
    logic [REGW-1:0]  req_rd;
    logic             uop_valid;
    logic             uop_ready;
    logic             uop_use_imm;
    logic [1:0]       uop_shift_dist;
    logic [IMMW-1:0]  uop_imm;
    logic [REGW-1:0]  uop_rd;
    logic             uop_src_zero;
    logic             busy;
    logic             done;

    imm_build_sequencer #(.DATAW(DATAW), .IMMW(IMMW), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_const(req_const), .req_rd(req_rd),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_use_imm(uop_use_imm), .uop_shift_dist(uop_shift_dist),
        .uop_imm(uop_imm), .uop_rd(uop_rd), .uop_src_zero(uop_src_zero),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: a constant becomes a list of (lane, byte) ops consumed on handshake.
    typedef struct packed { logic [1:0] lane; logic [7:0] b; } mop_t;
    mop_t            m_q[$];
    int              m_mode  = 0;   // 0 idle, 1 issuing, 2 done pulse
    logic            m_first = 1'b0;
    logic [REGW-1:0] m_rd    = '0;
    logic [7:0]      mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            m_mode  = 0;
            m_first = 1'b0;
            m_q.delete();
        end else if (m_mode == 0) begin
            if (req_valid) begin
                m_q.delete();
                for (int i = 0; i < 4; i++) begin
                    mb = req_const[8*i +: 8];
                    if (!SKIP || mb != 8'h00) m_q.push_back('{lane: 2'(i), b: mb});
                end
                if (m_q.size() == 0) m_q.push_back('{lane: 2'd0, b: 8'h00});
                m_rd    = req_rd;
                m_first = 1'b1;
                m_mode  = 1;
            end
        end else if (m_mode == 1) begin
            if (uop_ready) begin
                void'(m_q.pop_front());
                m_first = 1'b0;
                if (m_q.size() == 0) m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ctl", 64'({req_ready, uop_valid, uop_use_imm, busy, done, uop_src_zero}),
            64'({m_mode == 0, m_mode == 1, m_mode == 1, m_mode == 1, m_mode == 2,
                 m_mode == 1 && m_first}));
        if (m_mode == 1 && m_q.size() > 0)
            chk("payload", 64'({uop_shift_dist, uop_imm, uop_rd}),
                64'({m_q[0].lane, 3'b000, m_q[0].b, m_rd}));
    end

    // Monitor: log of accepted requests, issued ops, done pulses and ready edges.
    typedef struct {
        logic [1:0]      lane;
        logic [IMMW-1:0] imm;
        logic            sz;
        logic [REGW-1:0] rd;
        int              cyc;
    } op_t;
    op_t  ops_log[$];
    int   acc_cyc[4];
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   ready_cyc = 0;
    int   pres_cnt[4];
    logic prev_ready = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready && !flush && acc_cnt < 4) begin
                acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
            end
            if (uop_valid) pres_cnt[uop_shift_dist]++;
            if (uop_valid && uop_ready)
                ops_log.push_back('{uop_shift_dist, uop_imm, uop_src_zero, uop_rd, cyc});
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (req_ready && !prev_ready) ready_cyc = cyc;
            prev_ready = req_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        ops_log.delete();
        acc_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) pres_cnt[i] = 0;
    endtask

    task automatic check_op(input string nm, input int idx, input int lane, input int b,
                            input logic sz, input int rd);
        if (idx >= ops_log.size())
            chk({nm, "_present"}, 64'(ops_log.size()), 64'(idx + 1));
        else
            chk(nm, 64'({ops_log[idx].lane, ops_log[idx].imm, ops_log[idx].sz, ops_log[idx].rd}),
                64'({2'(lane), 11'(b), sz, 5'(rd)}));
    endtask

    // One request; uop_ready low for stall_n cycles starting stall_at cycles after accept.
    task automatic run_req(input logic [31:0] c, input logic [4:0] rd,
                           input int stall_at, input int stall_n, input string nm);
        clear_log();
        req_const = c;
        req_rd    = rd;
        req_valid = 1'b1;
        uop_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 40 && done_cnt == 0; k++) begin
            uop_ready = (k < stall_at || k >= stall_at + stall_n);
            tick();
        end
        uop_ready = 1'b1;
        chk({nm, "_done_once"}, 64'(done_cnt), 64'd1);
        tick();
        tick();
    endtask

    function automatic logic [63:0] rst_vec();
        return 64'({req_ready, uop_valid, uop_use_imm, uop_src_zero, busy, done,
                    uop_shift_dist, uop_imm, uop_rd});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        uop_ready = 1'b1;
        req_const = '0;
        req_rd    = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_init", rst_vec(), 64'({1'b1, 5'b0, 2'b0, 11'h0, 5'h0}));
        rst_n = 1'b1;
        tick();
        tick();

        // Basic sequence, no stalls.
        run_req(32'h12345678, 5'd3, 0, 0, "t1");
        chk("t1_acc", 64'(acc_cnt), 64'd1);
        chk("t1_nops", 64'(ops_log.size()), 64'd4);
        check_op("t1_op0", 0, 0, 'h78, 1'b1, 3);
        check_op("t1_op1", 1, 1, 'h56, 1'b0, 3);
        check_op("t1_op2", 2, 2, 'h34, 1'b0, 3);
        check_op("t1_op3", 3, 3, 'h12, 1'b0, 3);
        chk("t1_first_lat", 64'(ops_log[0].cyc - acc_cyc[0]), 64'd1);
        chk("t1_done_lat", 64'(done_cyc - acc_cyc[0]), 64'd5);
        chk("t1_ready_lat", 64'(ready_cyc - acc_cyc[0]), 64'd6);

        // Three stall cycles on lane 1.
        run_req(32'h12345678, 5'd3, 2, 3, "t2");
        chk("t2_done_lat", 64'(done_cyc - acc_cyc[0]), 64'd8);
        chk("t2_lane1_cycles", 64'(pres_cnt[1]), 64'd4);
        chk("t2_lane2_cycles", 64'(pres_cnt[2]), 64'd1);
        check_op("t2_op1", 1, 1, 'h56, 1'b0, 3);
        chk("t2_op1_cyc", 64'(ops_log[1].cyc - acc_cyc[0]), 64'd5);

        // Request held through ISSUE/DONE is only taken once back in IDLE.
        clear_log();
        req_const = 32'h12345678;
        req_rd    = 5'd3;
        req_valid = 1'b1;
        uop_ready = 1'b1;
        tick();
        req_const = 32'hDEADBEEF;
        req_rd    = 5'd7;
        for (int k = 0; k < 20 && acc_cnt < 2; k++) tick();
        req_valid = 1'b0;
        for (int k = 0; k < 20 && done_cnt < 2; k++) tick();
        chk("t3_acc", 64'(acc_cnt), 64'd2);
        chk("t3_acc_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
        chk("t3_nops", 64'(ops_log.size()), 64'd8);
        check_op("t3_op4", 4, 0, 'hEF, 1'b1, 7);
        check_op("t3_op5", 5, 1, 'hBE, 1'b0, 7);
        check_op("t3_op6", 6, 2, 'hAD, 1'b0, 7);
        check_op("t3_op7", 7, 3, 'hDE, 1'b0, 7);
        tick();
        tick();

        // Flush while lane 2 is presented (lanes 0 and 1 already accepted).
        clear_log();
        req_const = 32'hCAFEF00D;
        req_rd    = 5'd9;
        req_valid = 1'b1;
        uop_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_valid", 64'(uop_valid), 64'd0);
        chk("t4_ready", 64'(req_ready), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        repeat (6) tick();
        chk("t4_no_done", 64'(done_cnt), 64'd0);
        chk("t4_nops", 64'(ops_log.size()), 64'd3);
        check_op("t4_op2", 2, 2, 'hFE, 1'b0, 9);

        // Flush in IDLE blocks acceptance.
        clear_log();
        req_const = 32'h11111111;
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        tick();
        chk("t4b_no_accept", 64'(acc_cnt), 64'd0);
        chk("t4b_valid", 64'(uop_valid), 64'd0);

        // Zero bytes: skipped only when the option is built in.
        run_req(32'h00FF0000, 5'd20, 0, 0, "t6a");
        chk("t6a_nops", 64'(ops_log.size()), 64'(SKIP ? 1 : 4));
        check_op("t6a_op0", 0, SKIP ? 2 : 0, SKIP ? 'hFF : 'h00, 1'b1, 20);
        check_op("t6a_op_ff", SKIP ? 0 : 2, 2, 'hFF, SKIP ? 1'b1 : 1'b0, 20);
        chk("t6a_done_lat", 64'(done_cyc - acc_cyc[0]), 64'(SKIP ? 2 : 5));
        run_req(32'h00000000, 5'd21, 0, 0, "t6b");
        chk("t6b_nops", 64'(ops_log.size()), 64'(SKIP ? 1 : 4));
        check_op("t6b_op0", 0, 0, 'h00, 1'b1, 21);
        chk("t6b_done_lat", 64'(done_cyc - acc_cyc[0]), 64'(SKIP ? 2 : 5));

        // Asynchronous reset in mid-sequence.
        clear_log();
        req_const = 32'hA5A5A5A5;
        req_rd    = 5'd12;
        req_valid = 1'b1;
        uop_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", rst_vec(), 64'({1'b1, 5'b0, 2'b0, 11'h0, 5'h0}));
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        chk("t5_ready", 64'(req_ready), 64'd1);

        // Recovery after reset.
        run_req(32'h0BADF00D, 5'd31, 0, 0, "t7");
        chk("t7_nops", 64'(ops_log.size()), 64'd4);
        check_op("t7_op0", 0, 0, 'h0D, 1'b1, 31);
        check_op("t7_op3", 3, 3, 'h0B, 1'b0, 31);
        chk("t7_done_lat", 64'(done_cyc - acc_cyc[0]), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
